// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM command-port arbiter: FSM state
// encodings and default timeout sizing.
package sdram_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_FALL = 3'd2,
        DONE      = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam int TIMEOUT_CYC_DEF = 1023;
    localparam int TO_W_DEF        = 12;

endpackage

// File: rtl/sdram_arbiter_rr.sv
// Winner select for the two-master SDRAM arbiter. Purely combinational:
// fixed priority (M0 wins whenever it asks) or round-robin on ties, where
// the master that did not go last wins.
module sdram_arb_rr #(
    parameter int FIXED_PRIO = 0
) (
    input  logic m0_req,
    input  logic m1_req,
    input  logic last,
    output logic winner
);

    // Pick the next owner from the requests seen this cycle (0 = M0, 1 = M1).
    always_comb begin
        winner = 1'b0;
        if (FIXED_PRIO != 0) begin
            winner = m1_req && !m0_req;
        end else if (m0_req && m1_req) begin
            winner = !last;
        end else begin
            winner = m1_req;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbiter sharing the single SDRAM controller command port between M0
// (CPU) and M1 (display/DMA). One transaction at a time: grant in IDLE,
// hold the controller request until its level ack is seen, wait for the
// ack to fall, pulse done to the owner, then one GAP cycle so the master
// can drop its request before the next arbitration.
//
// Handshake: a master raises mN_req and holds it until its one-cycle
// mN_done; the controller request (sd_wr_req / sd_rd_req) stays high until
// the matching level ack is sampled high, and the transaction completes
// once that ack is sampled low again. A watchdog aborts a transaction that
// has not completed after TIMEOUT_CYC cycles in ISSUE/WAIT_FALL.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO  = 0,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic   clk_100m,
    input  logic   rst_n,
    input  logic   init_done,
    input  logic   m0_req,
    input  logic   m0_rw_n,
    output logic   m0_done,
    input  logic   m1_req,
    input  logic   m1_rw_n,
    output logic   m1_done,
    output logic   sd_wr_req,
    output logic   sd_rd_req,
    input  logic   sd_wr_ack,
    input  logic   sd_rd_ack,
    output logic   owner,
    output logic   busy,
    output logic   timeout_err,
    output state_t state_dbg
);

    // Counter value on the last cycle before the abort fires, so the
    // controller request is high for exactly TIMEOUT_CYC cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state_q;
    state_t          state_d;
    logic            owner_q;
    logic            last_q;
    logic            rw_lat_q;
    logic            abort_q;
    logic [TO_W-1:0] cnt_q;
    logic            winner;
    logic            sel_ack;
    logic            grant;
    logic            abort;
    logic            timing;

    sdram_arb_rr #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr (
        .m0_req (m0_req),
        .m1_req (m1_req),
        .last   (last_q),
        .winner (winner)
    );

    // Only the ack matching the latched direction matters.
    assign sel_ack = rw_lat_q ? sd_wr_ack : sd_rd_ack;
    assign timing  = (state_q == ISSUE) || (state_q == WAIT_FALL);

    // Next-state logic: grant, ack tracking and timeout abort.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_done && (m0_req || m1_req)) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = GAP;
                end else if (sel_ack) begin
                    state_d = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                if (cnt_q == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = GAP;
                end else if (!sel_ack) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping: owner, direction, fairness history, watchdog.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            rw_lat_q <= 1'b0;
            abort_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            abort_q <= abort;
            if (grant) begin
                owner_q  <= winner;
                rw_lat_q <= winner ? m1_rw_n : m0_rw_n;
                cnt_q    <= '0;
            end else if (timing) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if ((state_q == DONE) || abort) begin
                last_q <= owner_q;
            end
        end
    end

    assign sd_wr_req   = (state_q == ISSUE) &&  rw_lat_q;
    assign sd_rd_req   = (state_q == ISSUE) && !rw_lat_q;
    assign m0_done     = ((state_q == DONE) || abort_q) && !owner_q;
    assign m1_done     = ((state_q == DONE) || abort_q) &&  owner_q;
    assign timeout_err = abort_q;
    assign owner       = owner_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg   = state_q;

endmodule
